adc_sampler: RTL and testbench

ADC_SAMPLER -- requirements
Module: adc_sampler

---
 rtl/adc_sampler.sv | 175 +++++++++++++++++
 tb/tb_adc_sampler.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sampler.sv
// SPI ADC front end: periodic conversion, 16-bit serial capture,
// and a power-of-two moving average over the last samples.
module adc_sampler #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int AVG_LOG2      = 2
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               miso,
    output logic               sclk,
    output logic               cs_n,
    output logic signed [15:0] raw_adc_data,
    output logic               data_valid,
    output logic               busy
);

    localparam int DEPTH = 1 << AVG_LOG2;
    localparam int SW    = 16 + AVG_LOG2;
    localparam int PW    = $clog2(SAMPLE_PERIOD);
    localparam int IW    = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int FW    = AVG_LOG2 + 1;

    typedef enum logic [2:0] {
        IDLE,
        CS_SETUP,
        SHIFT,
        CS_HOLD,
        ACCUM
    } state_t;

    state_t               state_q, state_d;
    logic [PW-1:0]        per_q, per_d;
    logic [7:0]           div_q, div_d;
    logic [3:0]           bcnt_q, bcnt_d;
    logic [15:0]          shreg_q, shreg_d;
    logic                 sclk_q, sclk_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 dv_q, dv_d;
    logic signed [15:0]   raw_q, raw_d;
    logic signed [15:0]   buf_q [DEPTH];
    logic signed [15:0]   buf_d [DEPTH];
    logic signed [SW-1:0] sum_q, sum_d;
    logic [IW-1:0]        wp_q, wp_d;
    logic [FW-1:0]        fill_q, fill_d;

    logic                 start;
    logic                 div_end;
    logic signed [15:0]   sample;

    assign start   = (per_q == PW'(SAMPLE_PERIOD - 1));
    assign div_end = (div_q == 8'(CLK_DIV - 1));
    assign sample  = shreg_q;

    always_comb begin
        state_d = state_q;
        per_d   = start ? '0 : per_q + 1'b1;
        div_d   = div_q;
        bcnt_d  = bcnt_q;
        shreg_d = shreg_q;
        sclk_d  = sclk_q;
        cs_n_d  = cs_n_q;
        dv_d    = 1'b0;
        raw_d   = raw_q;
        buf_d   = buf_q;
        sum_d   = sum_q;
        wp_d    = wp_q;
        fill_d  = fill_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CS_SETUP;
                    cs_n_d  = 1'b0;
                    div_d   = '0;
                end
            end
            CS_SETUP: begin
                if (div_end) begin
                    state_d = SHIFT;
                    div_d   = '0;
                    bcnt_d  = '0;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SHIFT: begin
                if (!div_end) begin
                    div_d = div_q + 8'd1;
                end else begin
                    div_d  = '0;
                    sclk_d = !sclk_q;
                    // capture on the cycle sclk is driven high
                    if (!sclk_q) begin
                        shreg_d = {shreg_q[14:0], miso};
                    end else if (bcnt_q == 4'd15) begin
                        state_d = CS_HOLD;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                    end
                end
            end
            CS_HOLD: begin
                if (div_end) begin
                    state_d = ACCUM;
                    cs_n_d  = 1'b1;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            ACCUM: begin
                state_d     = IDLE;
                buf_d[wp_q] = sample;
                sum_d = sum_q + SW'(sample) - SW'(buf_q[wp_q]);
                wp_d  = (AVG_LOG2 == 0) ? '0 : wp_q + 1'b1;
                if (fill_q != FW'(DEPTH)) begin
                    fill_d = fill_q + 1'b1;
                end
                if (fill_d == FW'(DEPTH)) begin
                    dv_d  = 1'b1;
                    raw_d = 16'(sum_d >>> AVG_LOG2);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            per_q   <= '0;
            div_q   <= '0;
            bcnt_q  <= '0;
            shreg_q <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b1;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            raw_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            sum_q   <= '0;
            wp_q    <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            per_q   <= per_d;
            div_q   <= div_d;
            bcnt_q  <= bcnt_d;
            shreg_q <= shreg_d;
            sclk_q  <= sclk_d;
            cs_n_q  <= cs_n_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            raw_q   <= raw_d;
            buf_q   <= buf_d;
            sum_q   <= sum_d;
            wp_q    <= wp_d;
            fill_q  <= fill_d;
        end
    end

    assign sclk         = sclk_q;
    assign cs_n         = cs_n_q;
    assign busy         = busy_q;
    assign data_valid   = dv_q;
    assign raw_adc_data = raw_q;

endmodule

// File: tb/tb_adc_sampler.sv
// Directed bench for adc_sampler: SPI framing, averaging,
// signed floor, reset mid-shift and back-to-back conversions.
module tb_adc_sampler;

    localparam int CD = 2;
    localparam int SP = 2 * CD * 18;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        miso = 1'b0;
    logic        sclk0, cs_n0, dv0, busy0;
    logic        sclk1, cs_n1, dv1, busy1;
    logic [15:0] raw0, raw1;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ref_cyc  = 0;
    int pulses0  = 0;
    int pulses1  = 0;
    logic prev_dv0 = 1'b0;

    logic [15:0] next_word = 16'h0000;
    logic [15:0] cur_word  = 16'h0000;
    int          idx       = 0;

    adc_sampler #(
        .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_LOG2(2)
    ) u0 (
        .clk(clk), .reset_n(reset_n), .miso(miso),
        .sclk(sclk0), .cs_n(cs_n0), .raw_adc_data(raw0),
        .data_valid(dv0), .busy(busy0)
    );

    adc_sampler #(
        .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .AVG_LOG2(0)
    ) u1 (
        .clk(clk), .reset_n(reset_n), .miso(miso),
        .sclk(sclk1), .cs_n(cs_n1), .raw_adc_data(raw1),
        .data_valid(dv1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // ADC model: MSB on cs_n fall, next bit after each sclk rise
    always @(negedge cs_n0) begin
        idx      = 0;
        cur_word = next_word;
        miso     = next_word[15];
    end

    always @(posedge sclk0) begin
        idx++;
        miso = (idx < 16) ? cur_word[15 - idx] : 1'b0;
    end

    always @(posedge clk) begin
        #1;
        if (dv0) begin
            pulses0++;
            n_assert++;
            assert (prev_dv0 === 1'b0) else begin
                n_fail++;
                $error("FAIL dv_double observed=%b expected=0",
                       prev_dv0);
            end
        end
        if (dv1) pulses1++;
        prev_dv0 = dv0;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h",
                   tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fall(output logic ok);
        int n;
        n = 0;
        while (cs_n0 !== 1'b0 && n < 4 * SP) begin
            tick();
            n++;
        end
        ok = (cs_n0 === 1'b0);
        chk("cs_fall_timeout", 32'(cs_n0), 32'd0);
    endtask

    task automatic conv(input logic [15:0] w,
                        input logic        ev,
                        input logic [15:0] er);
        int   low;
        int   rises;
        logic ps;
        logic ok;
        next_word = w;
        wait_fall(ok);
        if (!ok) return;
        chk("cs_fall_gap", cyc - ref_cyc, SP);
        ref_cyc = cyc;
        chk("sclk_at_fall", 32'(sclk0), 32'd0);
        low   = 1;
        rises = 0;
        ps    = sclk0;
        while (low < 200) begin
            tick();
            if (cs_n0 !== 1'b0) break;
            low++;
            if (sclk0 === 1'b1 && ps === 1'b0) rises++;
            ps = sclk0;
        end
        chk("cs_low_cycles", low, 34 * CD);
        chk("sclk_rises", rises, 16);
        chk("sclk_at_rise", 32'(sclk0), 32'd0);
        tick();
        chk("dv", 32'(dv0), 32'(ev));
        chk("raw", 32'(raw0), 32'(er));
        chk("dv_avg0", 32'(dv1), 32'd1);
        chk("raw_avg0", 32'(raw1), 32'(w));
        tick();
        chk("dv_pulse", 32'(dv0), 32'd0);
    endtask

    initial begin
        int   rises;
        int   n;
        logic ps;
        logic ok;

        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        repeat (3) tick();
        chk("rst_cs_n", 32'(cs_n0), 32'd1);
        chk("rst_sclk", 32'(sclk0), 32'd0);
        chk("rst_busy", 32'(busy0), 32'd0);
        chk("rst_dv", 32'(dv0), 32'd0);
        chk("rst_raw", 32'(raw0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ref_cyc = cyc;

        // fill with a constant
        conv(16'h1000, 1'b0, 16'h0000);
        conv(16'h1000, 1'b0, 16'h0000);
        conv(16'h1000, 1'b0, 16'h0000);
        conv(16'h1000, 1'b1, 16'h1000);

        // drain to zero, then ramp
        conv(16'h0000, 1'b1, 16'h0C00);
        conv(16'h0000, 1'b1, 16'h0800);
        conv(16'h0000, 1'b1, 16'h0400);
        conv(16'h0000, 1'b1, 16'h0000);
        conv(16'h0001, 1'b1, 16'h0000);
        conv(16'h0002, 1'b1, 16'h0000);
        conv(16'h0003, 1'b1, 16'h0001);
        conv(16'h0004, 1'b1, 16'h0002);

        // negative values and full-scale extremes
        conv(16'hFFFF, 1'b1, 16'h0002);
        conv(16'hFFFF, 1'b1, 16'h0001);
        conv(16'hFFFF, 1'b1, 16'h0000);
        conv(16'hFFFF, 1'b1, 16'hFFFF);
        conv(16'hFFFE, 1'b1, 16'hFFFE);
        conv(16'h8000, 1'b1, 16'hDFFF);
        conv(16'h8000, 1'b1, 16'hBFFF);
        conv(16'h8000, 1'b1, 16'h9FFF);
        conv(16'h8000, 1'b1, 16'h8000);
        conv(16'h7FFF, 1'b1, 16'hBFFF);
        conv(16'h7FFF, 1'b1, 16'hFFFF);
        conv(16'h7FFF, 1'b1, 16'h3FFF);
        conv(16'h7FFF, 1'b1, 16'h7FFF);

        // reset in the middle of bit 7
        next_word = 16'h5A5A;
        wait_fall(ok);
        rises = 0;
        ps    = sclk0;
        n     = 0;
        while (rises < 8 && n < 200) begin
            tick();
            n++;
            if (sclk0 === 1'b1 && ps === 1'b0) rises++;
            ps = sclk0;
        end
        chk("mid_rises", rises, 8);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_cs_n", 32'(cs_n0), 32'd1);
        chk("mid_sclk", 32'(sclk0), 32'd0);
        chk("mid_busy", 32'(busy0), 32'd0);
        chk("mid_raw", 32'(raw0), 32'd0);
        chk("mid_raw_avg0", 32'(raw1), 32'd0);
        repeat (3) tick();
        chk("mid_dv", 32'(dv0), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        ref_cyc = cyc;

        conv(16'h0100, 1'b0, 16'h0000);
        conv(16'h0100, 1'b0, 16'h0000);
        conv(16'h0100, 1'b0, 16'h0000);
        conv(16'h0100, 1'b1, 16'h0100);

        tick();
        chk("pulses_avg4", pulses0, 23);
        chk("pulses_avg1", pulses1, 29);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
